// File: rtl/ioq_hdr_inserter_pkg.sv
// rtl/ioq_hdr_inserter_pkg.sv - shared constants, FSM encodings and helpers for the IO-queue header inserter
package ioq_hdr_inserter_pkg;

  // IO-queue module header: ctrl tag and field positions within the header word
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam int IOQ_BYTE_LEN_POS = 0;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_WORD_LEN_POS = 32;
  localparam int IOQ_DST_PORT_POS = 48;

  // Write-side FSM
  localparam logic [0:0] W_ACCEPT = 1'b0;
  localparam logic [0:0] W_DROP   = 1'b1;

  // Read-side FSM
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_HDR  = 2'd1;
  localparam logic [1:0] R_BODY = 2'd2;

  // One-hot eop ctrl to byte count: bit (7-k) set means k+1 valid bytes, MSB-first
  function automatic logic [3:0] valid_bytes(input logic [7:0] ctrl);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (ctrl[7-k]) n = 4'(k + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/ioq_pkt_buf.sv
// rtl/ioq_pkt_buf.sv - simple dual-port packet RAM with registered read holding {ctrl,data}
module ioq_pkt_buf #(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [1 << ADDR_BITS];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output holds while rd_en is low so it can act as a pipeline stage
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ioq_hdr_inserter.sv
// rtl/ioq_hdr_inserter.sv - store-and-forward frame buffer that prepends the IO-queue module header
module ioq_hdr_inserter
  import ioq_hdr_inserter_pkg::*;
#(
  parameter int          DATA_WIDTH          = 64,
  parameter int          CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter logic [15:0] SRC_PORT            = 16'd0,
  parameter int          BUF_DEPTH_BITS      = 9,
  parameter int          MAX_PKT_WORDS       = 256,
  parameter int          LEN_FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  pkt_stored,
  output logic                  pkt_dropped
);

  localparam int RAM_W     = DATA_WIDTH + CTRL_WIDTH;
  localparam int LEN_DEPTH = 1 << LEN_FIFO_DEPTH_BITS;
  localparam logic [BUF_DEPTH_BITS:0]      BUF_WORDS = (BUF_DEPTH_BITS+1)'(1 << BUF_DEPTH_BITS);
  localparam logic [BUF_DEPTH_BITS:0]      FREE_MIN  = (BUF_DEPTH_BITS+1)'(2);
  localparam logic [LEN_FIFO_DEPTH_BITS:0] LEN_HIGH  = (LEN_FIFO_DEPTH_BITS+1)'(LEN_DEPTH - 2);
  localparam logic [LEN_FIFO_DEPTH_BITS:0] LEN_ONE   = (LEN_FIFO_DEPTH_BITS+1)'(1);
  localparam logic [15:0]                  MAX_CNT   = 16'(MAX_PKT_WORDS);

  // Buffer pointers and write-side state
  logic [BUF_DEPTH_BITS-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [BUF_DEPTH_BITS:0]   free_words;
  logic [0:0]                w_state;
  logic [15:0]               word_cnt;
  logic                      rdy_q, accept, eop, buf_wr;
  logic [15:0]               byte_len, word_len;

  // Length FIFO of committed frames: {byte_len, word_len}
  logic [31:0]                    len_mem [LEN_DEPTH];
  logic [LEN_FIFO_DEPTH_BITS-1:0] len_wr_idx, len_rd_idx;
  logic [LEN_FIFO_DEPTH_BITS:0]   len_cnt;
  logic                           len_push, len_pop;
  logic [15:0]                    head_bl, head_wl, next_wl;

  // Read side
  logic [1:0]            r_state;
  logic [15:0]           rd_left, out_left;
  logic                  buf_valid, out_valid, rd_en, s1_pop, load_ok;
  logic [RAM_W-1:0]      buf_rd_data;
  logic [DATA_WIDTH-1:0] hdr_word, out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  // Occupancy is measured against rd_ptr: words already pulled into the read pipeline are free
  assign free_words = BUF_WORDS - {1'b0, wr_ptr - rd_ptr};
  // Margin of two words covers the word already in flight plus the one-cycle rdy latency
  assign in_rdy     = !reset && (free_words > FREE_MIN) && !(len_cnt >= LEN_HIGH);
  assign accept     = in_wr && rdy_q;
  assign eop        = (in_ctrl != '0);
  assign byte_len   = {word_cnt[12:0], 3'b000} + {12'd0, valid_bytes(in_ctrl)};
  assign word_len   = word_cnt + 16'd1;

  // Decide whether the accepted word lands in the buffer and whether it commits a frame
  always_comb begin
    buf_wr   = 1'b0;
    len_push = 1'b0;
    if (accept && (w_state == W_ACCEPT) && (word_cnt != MAX_CNT)) begin
      buf_wr   = 1'b1;
      len_push = eop;
    end
  end

  // Write FSM: accept words, commit on eop, rewind and discard oversize frames
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state     <= W_ACCEPT;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      word_cnt    <= '0;
      rdy_q       <= 1'b0;
      pkt_stored  <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      rdy_q       <= in_rdy;
      pkt_stored  <= 1'b0;
      pkt_dropped <= 1'b0;
      if (accept) begin
        case (w_state)
          W_ACCEPT: begin
            if (word_cnt == MAX_CNT) begin
              wr_ptr   <= commit_ptr;
              word_cnt <= '0;
              if (eop) pkt_dropped <= 1'b1;
              else     w_state     <= W_DROP;
            end else if (eop) begin
              wr_ptr     <= wr_ptr + 1'b1;
              commit_ptr <= wr_ptr + 1'b1;
              word_cnt   <= '0;
              pkt_stored <= 1'b1;
            end else begin
              wr_ptr   <= wr_ptr + 1'b1;
              word_cnt <= word_cnt + 16'd1;
            end
          end
          default: begin
            if (eop) begin
              pkt_dropped <= 1'b1;
              w_state     <= W_ACCEPT;
            end
          end
        endcase
      end
    end
  end

  // Length FIFO storage (no reset needed; validity is tracked by len_cnt)
  always_ff @(posedge clk) begin
    if (len_push) len_mem[len_wr_idx] <= {byte_len, word_len};
  end

  // Length FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      len_wr_idx <= '0;
      len_rd_idx <= '0;
      len_cnt    <= '0;
    end else begin
      if (len_push) len_wr_idx <= len_wr_idx + 1'b1;
      if (len_pop)  len_rd_idx <= len_rd_idx + 1'b1;
      case ({len_push, len_pop})
        2'b10:   len_cnt <= len_cnt + 1'b1;
        2'b01:   len_cnt <= len_cnt - 1'b1;
        default: len_cnt <= len_cnt;
      endcase
    end
  end

  assign head_bl = len_mem[len_rd_idx][31:16];
  assign head_wl = len_mem[len_rd_idx][15:0];
  assign next_wl = len_mem[len_rd_idx + 1'b1][15:0];

  ioq_pkt_buf #(
    .WIDTH     (RAM_W),
    .ADDR_BITS (BUF_DEPTH_BITS)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (wr_ptr),
    .wr_data ({in_ctrl, in_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (buf_rd_data)
  );

  // Header word for the frame at the head of the length FIFO; destination field left zero
  always_comb begin
    hdr_word = '0;
    hdr_word[IOQ_BYTE_LEN_POS +: 16] = head_bl;
    hdr_word[IOQ_SRC_PORT_POS +: 16] = SRC_PORT;
    hdr_word[IOQ_WORD_LEN_POS +: 16] = head_wl;
    hdr_word[IOQ_DST_PORT_POS +: 16] = 16'd0;
  end

  // Two-stage read pipeline: RAM output register (buf_valid) feeding the output register (out_valid)
  assign load_ok = !out_valid || out_rdy;
  assign s1_pop  = (r_state == R_BODY) && buf_valid && load_ok;
  assign rd_en   = (r_state != R_IDLE) && (rd_left != 16'd0) && (!buf_valid || s1_pop);
  assign len_pop = s1_pop && (out_left == 16'd1);

  // Read FSM: header, then body words; chain straight into the next committed frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      rd_ptr     <= '0;
      rd_left    <= '0;
      out_left   <= '0;
      buf_valid  <= 1'b0;
      out_valid  <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_left <= rd_left - 16'd1;
      end
      if (rd_en)       buf_valid <= 1'b1;
      else if (s1_pop) buf_valid <= 1'b0;
      if (load_ok) out_valid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (len_cnt != '0) begin
            rd_left  <= head_wl;
            out_left <= head_wl;
            r_state  <= R_HDR;
          end
        end
        R_HDR: begin
          if (load_ok) begin
            out_valid  <= 1'b1;
            out_data_q <= hdr_word;
            out_ctrl_q <= IO_QUEUE_STAGE_NUM;
            r_state    <= R_BODY;
          end
        end
        default: begin
          if (s1_pop) begin
            out_valid  <= 1'b1;
            out_data_q <= buf_rd_data[DATA_WIDTH-1:0];
            out_ctrl_q <= buf_rd_data[RAM_W-1:DATA_WIDTH];
            out_left   <= out_left - 16'd1;
            if (out_left == 16'd1) begin
              if (len_cnt > LEN_ONE) begin
                rd_left  <= next_wl;
                out_left <= next_wl;
                r_state  <= R_HDR;
              end else begin
                r_state <= R_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign out_wr   = out_valid && out_rdy;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;

endmodule

// File: tb/tb_ioq_hdr_inserter.sv
// tb/tb_ioq_hdr_inserter.sv - scoreboard testbench for ioq_hdr_inserter
module tb_ioq_hdr_inserter;

  localparam logic [15:0] SRC = 16'h0005;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        pkt_stored;
  logic        pkt_dropped;

  ioq_hdr_inserter #(
    .DATA_WIDTH          (64),
    .CTRL_WIDTH          (8),
    .SRC_PORT            (SRC),
    .BUF_DEPTH_BITS      (9),
    .MAX_PKT_WORDS       (256),
    .LEN_FIFO_DEPTH_BITS (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_wr       (in_wr),
    .in_rdy      (in_rdy),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_wr      (out_wr),
    .out_rdy     (out_rdy),
    .pkt_stored  (pkt_stored),
    .pkt_dropped (pkt_dropped)
  );

  always #5 clk = ~clk;

  logic [71:0] exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  stored_seen = 0;
  int  dropped_seen = 0;
  int  exp_stored = 0;
  int  exp_dropped = 0;
  int  rdy_mode = 0;
  bit  junk_en = 1'b0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) rdy_prev <= in_rdy;

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [63:0] word_of(input int f, input int i);
    return {16'hc0de, 16'(f), 16'(i), 16'(f * 7 + i)};
  endfunction

  function automatic logic [71:0] hdr(input int bl, input int wl);
    return {8'hff, 16'h0000, 16'(wl), SRC, 16'(bl)};
  endfunction

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = held low
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ~out_rdy;
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (pkt_stored)  stored_seen++;
      if (pkt_dropped) dropped_seen++;
      if (out_wr) begin
        tests++;
        if (out_rdy !== 1'b1) begin
          fails++;
          $display("FAIL out_wr_without_rdy got out_rdy=%b required 1", out_rdy);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word got %h_%h required no output", out_ctrl, out_data);
        end else begin
          logic [71:0] e;
          e = exp_q.pop_front();
          if ({out_ctrl, out_data} !== e) begin
            fails++;
            $display("FAIL out_word got %h_%h required %h_%h", out_ctrl, out_data, e[71:64], e[63:0]);
          end
        end
      end
    end
  end

  // Drive one word, respecting the one-cycle-delayed in_rdy; optionally inject illegal writes while stalled
  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_prev) begin
        in_wr = 1'b1; in_data = d; in_ctrl = c;
        break;
      end
      in_wr = junk_en; in_data = 64'hdead_beef_dead_beef; in_ctrl = 8'h01;
      n++;
      if (n > 5000) begin
        tests++; fails++;
        $display("FAIL in_rdy_timeout got stalled %0d cycles required < 5000", n);
        finish_tb();
      end
    end
  endtask

  task automatic end_stream();
    @(posedge clk); #1;
    in_wr = 1'b0; in_ctrl = 8'h00;
  endtask

  task automatic send_frame(input int f, input int nw, input logic [7:0] lc, input int bl, input bit keep);
    if (keep) begin
      exp_q.push_back(hdr(bl, nw));
      for (int i = 0; i < nw; i++) exp_q.push_back({(i == nw - 1) ? lc : 8'h00, word_of(f, i)});
      exp_stored++;
    end
    for (int i = 0; i < nw; i++) drive_word(word_of(f, i), (i == nw - 1) ? lc : 8'h00);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    check({name, "_drained"}, 72'(exp_q.size()), 72'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check({name, "_out_wr"},      72'(out_wr),      72'd0);
    check({name, "_out_data"},    72'(out_data),    72'd0);
    check({name, "_out_ctrl"},    72'(out_ctrl),    72'd0);
    check({name, "_pkt_stored"},  72'(pkt_stored),  72'd0);
    check({name, "_pkt_dropped"}, 72'(pkt_dropped), 72'd0);
    check({name, "_in_rdy"},      72'(in_rdy),      72'd0);
  endtask

  initial begin
    #500000;
    tests++; fails++;
    $display("FAIL watchdog got timeout required completion");
    finish_tb();
  end

  initial begin
    int lat;
    bit saw_stall;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset0");
    @(posedge clk); #1;
    reset = 1'b0;

    // 64-byte frame: header latency and gap-free body
    send_frame(1, 8, 8'h01, 64, 1'b1);
    end_stream();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_wr) begin lat = k; break; end
    end
    tests++;
    if (lat == 0 || lat > 3) begin
      fails++;
      $display("FAIL hdr_latency got %0d required 1..3", lat);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("body_no_gap", 72'(out_wr), 72'd1);
    end
    wait_drain("f64");
    check("stored_f64", 72'(stored_seen), 72'(exp_stored));

    // 60-byte frame (last ctrl 0x10 -> 4 bytes)
    send_frame(2, 8, 8'h10, 60, 1'b1);
    end_stream();
    wait_drain("f60");
    check("stored_f60", 72'(stored_seen), 72'(exp_stored));

    // Oversize frames: 257 words ending in eop, and 300 words through the drop state; then a clean frame
    send_frame(3, 257, 8'h01, 0, 1'b0);
    exp_dropped++;
    send_frame(4, 300, 8'h01, 0, 1'b0);
    exp_dropped++;
    send_frame(5, 8, 8'h01, 64, 1'b1);
    end_stream();
    wait_drain("drop");
    check("dropped_cnt", 72'(dropped_seen), 72'(exp_dropped));
    check("stored_drop", 72'(stored_seen), 72'(exp_stored));

    // 20 back-to-back frames with out_rdy toggling
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) send_frame(100 + f, 8, 8'h01, 64, 1'b1);
    end_stream();
    wait_drain("toggle");
    check("stored_toggle", 72'(stored_seen), 72'(exp_stored));
    rdy_mode = 0;

    // Buffer-full stall with illegal writes injected while in_rdy is low
    rdy_mode = 2;
    junk_en = 1'b1;
    saw_stall = 1'b0;
    fork
      begin
        for (int f = 0; f < 7; f++) send_frame(200 + f, 100, 8'h80, 793, 1'b1);
        end_stream();
      end
      begin
        for (int n = 0; n < 3000; n++) begin
          @(negedge clk);
          if (!in_rdy) begin saw_stall = 1'b1; break; end
        end
        repeat (20) @(posedge clk);
        rdy_mode = 0;
      end
    join
    junk_en = 1'b0;
    check("saw_stall", 72'(saw_stall), 72'd1);
    wait_drain("full");
    check("stored_full", 72'(stored_seen), 72'(exp_stored));

    // Reset in the middle of a frame (after word 4), then a clean 5-word frame
    for (int i = 0; i < 4; i++) drive_word(word_of(50, i), 8'h00);
    end_stream();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(51, 5, 8'h02, 39, 1'b1);
    end_stream();
    wait_drain("after_reset");
    check("stored_final", 72'(stored_seen), 72'(exp_stored));
    check("dropped_final", 72'(dropped_seen), 72'(exp_dropped));

    finish_tb();
  end

endmodule
